// File: rtl/led_ctrl_pkg.sv
// Purpose  : shared encodings for the LED pattern controller (command modes, FSM states).
// Latency  : n/a (constants only).
// Backpres.: n/a.
package led_ctrl_pkg;

  // Command / active-mode encodings carried on cfg_mode and mode_cur
  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_SLOW  = 2'd1;
  localparam logic [1:0] MODE_FAST  = 2'd2;
  localparam logic [1:0] MODE_CHASE = 2'd3;

  // Controller FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SWITCH = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

endpackage : led_ctrl_pkg

// File: rtl/led_tick_gen.sv
// Purpose  : shared prescaler; one-cycle tick every TICK_CYCLES+1 enabled clocks.
// Latency  : tick is combinational from the registered count (asserted while count==TICK_CYCLES).
// Backpres.: none; clr/en simply hold the count at zero.
// Ports:
//   sys_clk, sys_rst_n : clock, async active-low reset
//   clr                : force count to 0 (priority over en)
//   en                 : count enable
//   tick               : high for the single cycle the count sits at its terminal value
module led_tick_gen #(
  parameter int TICK_CYCLES = 2_499_999  // must be >= 1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICK_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(TICK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  // Terminal-value compare means the counter never needs to overflow.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == TERM);

endmodule : led_tick_gen

// File: rtl/led_mode_ctrl.sv
// Purpose  : LED bank pattern sequencer (off / slow blink / fast blink / chase) driven by mode commands.
// Latency  : command accepted at edge k -> SWITCH in cycle k+1 -> start pattern on led_out from cycle k+2.
// Backpres.: cfg_ready drops for the single SWITCH cycle; otherwise commands are always accepted.
// Ports:
//   sys_clk, sys_rst_n   : clock, async active-low reset
//   cfg_valid/cfg_ready  : mode command handshake, cfg_mode sampled on acceptance
//   cfg_mode [1:0]       : 0=OFF 1=SLOW 2=FAST 3=CHASE
//   led_out [LED_NUM-1:0]: registered LED drive, 1 = lit
//   mode_cur [1:0]       : registered currently active mode
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int TICK_CYCLES = 2_499_999,
  parameter int SLOW_TICKS  = 10,
  parameter int FAST_TICKS  = 2,
  parameter int LED_NUM     = 4   // must be >= 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               cfg_valid,
  input  logic [1:0]         cfg_mode,
  output logic               cfg_ready,
  output logic [LED_NUM-1:0] led_out,
  output logic [1:0]         mode_cur
);

  localparam int SW = $clog2(SLOW_TICKS + 1);
  localparam logic [SW-1:0] SLOW_LAST = SW'(SLOW_TICKS - 1);
  localparam logic [SW-1:0] FAST_LAST = SW'(FAST_TICKS - 1);
  localparam logic [LED_NUM-1:0] LED_ONE = {{(LED_NUM-1){1'b0}}, 1'b1};

  logic [1:0]         state_q, state_d;
  logic [1:0]         mode_req_q, mode_req_d;  // mode latched at acceptance, applied in SWITCH
  logic [1:0]         mode_cur_q, mode_cur_d;
  logic [SW-1:0]      step_q, step_d;
  logic [LED_NUM-1:0] led_q, led_d;

  logic          accept;
  logic          tick;
  logic          in_run;
  logic [SW-1:0] step_last;

  assign in_run    = (state_q == ST_RUN);
  assign cfg_ready = (state_q != ST_SWITCH);
  assign accept    = cfg_valid && cfg_ready;
  assign step_last = (mode_cur_q == MODE_FAST) ? FAST_LAST : SLOW_LAST;

  // Timebase only runs in RUN, so the first step period starts at the first RUN cycle.
  led_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .clr      (!in_run),
    .en       (in_run),
    .tick     (tick)
  );

  always_comb begin
    state_d    = state_q;
    mode_req_d = mode_req_q;
    mode_cur_d = mode_cur_q;
    step_d     = step_q;
    led_d      = led_q;
    unique case (state_q)
      ST_IDLE: begin
        led_d      = '0;
        mode_cur_d = MODE_OFF;
        step_d     = '0;
        if (accept && (cfg_mode != MODE_OFF)) begin
          mode_req_d = cfg_mode;
          state_d    = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        mode_cur_d = mode_req_q;
        step_d     = '0;
        led_d      = (mode_req_q == MODE_CHASE) ? LED_ONE : '1;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        // A new command takes priority; any coincident tick is dropped.
        if (accept) begin
          if (cfg_mode == MODE_OFF) begin
            state_d    = ST_IDLE;
            led_d      = '0;
            mode_cur_d = MODE_OFF;
            step_d     = '0;
          end else begin
            state_d    = ST_SWITCH;
            mode_req_d = cfg_mode;
          end
        end else if (tick) begin
          if (step_q == step_last) begin
            step_d = '0;
            if (mode_cur_q == MODE_CHASE) begin
              led_d = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
            end else begin
              led_d = ~led_q;
            end
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      mode_req_q <= MODE_OFF;
      mode_cur_q <= MODE_OFF;
      step_q     <= '0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_req_q <= mode_req_d;
      mode_cur_q <= mode_cur_d;
      step_q     <= step_d;
      led_q      <= led_d;
    end
  end

  assign led_out  = led_q;
  assign mode_cur = mode_cur_q;

endmodule : led_mode_ctrl

// File: tb/tb_led_mode_ctrl.sv
// Purpose  : directed self-checking bench for led_mode_ctrl (TICK_CYCLES=3, SLOW=4, FAST=2, LED_NUM=4).
// Latency  : slow/chase step = 16 clocks, fast step = 8 clocks, first change 2 cycles after accept.
// Backpres.: drives cfg_valid per handshake; outputs sampled 1 time unit after each rising edge.
module tb_led_mode_ctrl;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       cfg_valid;
  logic [1:0] cfg_mode;
  logic       cfg_ready;
  logic [3:0] led_out;
  logic [1:0] mode_cur;
  logic       clk_en;

  int n_checks;
  int n_fail;

  led_mode_ctrl #(
    .TICK_CYCLES(3),
    .SLOW_TICKS (4),
    .FAST_TICKS (2),
    .LED_NUM    (4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .cfg_valid(cfg_valid),
    .cfg_mode (cfg_mode),
    .cfg_ready(cfg_ready),
    .led_out  (led_out),
    .mode_cur (mode_cur)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = clk_en ? ~sys_clk : 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle just past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Present a command starting now; it is taken at the next edge (ready is high in IDLE/RUN).
  task automatic accept(input logic [1:0] m);
    cfg_valid = 1'b1;
    cfg_mode  = m;
    @(posedge sys_clk);
    #1;
    cfg_valid = 1'b0;
    cfg_mode  = 2'd0;
  endtask

  logic [3:0] chase_pat [0:4];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    clk_en    = 1'b0;
    cfg_valid = 1'b0;
    cfg_mode  = 2'd0;
    sys_rst_n = 1'b0;
    chase_pat[0] = 4'b0001;
    chase_pat[1] = 4'b0010;
    chase_pat[2] = 4'b0100;
    chase_pat[3] = 4'b1000;
    chase_pat[4] = 4'b0001;

    // 1. Reset with no clock running, then release.
    #10;
    check("rst_led",   32'(led_out),   32'h0);
    check("rst_mode",  32'(mode_cur),  32'h0);
    check("rst_ready", 32'(cfg_ready), 32'h1);
    sys_rst_n = 1'b1;
    #10;
    check("rel_led",   32'(led_out),   32'h0);
    check("rel_mode",  32'(mode_cur),  32'h0);
    check("rel_ready", 32'(cfg_ready), 32'h1);
    clk_en = 1'b1;
    step(2);

    // IDLE ignores an OFF command.
    accept(2'd0);
    check("idle_off_ready", 32'(cfg_ready), 32'h1);
    check("idle_off_led",   32'(led_out),   32'h0);
    step(1);
    check("idle_off_ready2", 32'(cfg_ready), 32'h1);

    // 2. SLOW: F from k+2, 0 from k+18, F from k+34.
    accept(2'd1);                                      // cycle k+1
    check("slow_sw_ready", 32'(cfg_ready), 32'h0);
    check("slow_sw_led",   32'(led_out),   32'h0);
    step(1);                                           // k+2
    check("slow_k2_led",   32'(led_out),   32'hF);
    check("slow_k2_mode",  32'(mode_cur),  32'h1);
    check("slow_k2_ready", 32'(cfg_ready), 32'h1);
    step(15);                                          // k+17
    check("slow_k17_led", 32'(led_out), 32'hF);
    step(1);                                           // k+18
    check("slow_k18_led", 32'(led_out), 32'h0);
    step(15);                                          // k+33
    check("slow_k33_led", 32'(led_out), 32'h0);
    step(1);                                           // k+34
    check("slow_k34_led", 32'(led_out), 32'hF);

    // 3. CHASE: 0001 -> 0010 -> 0100 -> 1000 -> 0001, 16 cycles each.
    accept(2'd3);
    check("chase_sw_led", 32'(led_out), 32'hF);
    step(1);
    check("chase_start", 32'(led_out),  32'h1);
    check("chase_mode",  32'(mode_cur), 32'h3);
    for (int i = 0; i < 4; i++) begin
      step(15);
      check("chase_hold", 32'(led_out), 32'(chase_pat[i]));
      step(1);
      check("chase_next", 32'(led_out), 32'(chase_pat[i+1]));
    end

    // 4. FAST: F/0 toggle every 8 cycles.
    accept(2'd2);
    check("fast_sw_mode", 32'(mode_cur), 32'h3);
    step(1);
    check("fast_start", 32'(led_out),  32'hF);
    check("fast_mode",  32'(mode_cur), 32'h2);
    for (int i = 0; i < 3; i++) begin
      step(7);
      check("fast_hold", 32'(led_out), (i % 2 == 0) ? 32'hF : 32'h0);
      step(1);
      check("fast_next", 32'(led_out), (i % 2 == 0) ? 32'h0 : 32'hF);
    end

    // 5. CHASE to 0100, then mode 1 accepted on the tick that would rotate to 1000.
    accept(2'd3);                                      // m+1
    step(33);                                          // m+34
    check("c5_at_0100", 32'(led_out), 32'h4);
    step(15);                                          // m+49: tick cycle, step at last
    check("c5_pre_acc", 32'(led_out), 32'h4);
    cfg_valid = 1'b1;
    cfg_mode  = 2'd1;
    step(1);                                           // k+1 (SWITCH), valid still held
    check("c5_sw_ready",  32'(cfg_ready), 32'h0);
    check("c5_no_rotate", 32'(led_out),   32'h4);
    step(1);                                           // k+2
    cfg_valid = 1'b0;
    cfg_mode  = 2'd0;
    check("c5_k2_led",  32'(led_out),  32'hF);
    check("c5_k2_mode", 32'(mode_cur), 32'h1);
    step(15);                                          // k+17
    check("c5_k17_led", 32'(led_out), 32'hF);
    step(1);                                           // k+18
    check("c5_k18_led", 32'(led_out), 32'h0);

    // 6. OFF from RUN, then async reset mid-RUN.
    accept(2'd0);
    check("off_led",   32'(led_out),   32'h0);
    check("off_mode",  32'(mode_cur),  32'h0);
    check("off_ready", 32'(cfg_ready), 32'h1);
    step(20);
    check("off_stay_led", 32'(led_out), 32'h0);
    accept(2'd1);
    step(1);
    check("r6_led", 32'(led_out), 32'hF);
    step(3);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("arst_led",   32'(led_out),   32'h0);
    check("arst_mode",  32'(mode_cur),  32'h0);
    check("arst_ready", 32'(cfg_ready), 32'h1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step(20);
    check("post_rst_led",  32'(led_out),  32'h0);
    check("post_rst_mode", 32'(mode_cur), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_led_mode_ctrl
